vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Parametrised VGA/raster timing generator; next generation of the fixed 640x480 vga block.
//  Produces hSync/vSync, dataEnable and pixel coordinates for any mode set by parameters.
//  Derives the pixel rate from the system clock via an integer clock-enable divider.
//  Adds pixel/line/frame strobes and a synchronous restart. Feeds sprite/pixel pipelines and the VGA pins.
// PARAMETERS
//  H_ACTIVE 640   visible pixels per line
//  H_FP     16    horizontal front porch, pixels
//  H_SYNC   96    horizontal sync width, pixels
//  H_BP     48    horizontal back porch, pixels
//  V_ACTIVE 480   visible lines per frame
//  V_FP     10    vertical front porch, lines
//  V_SYNC   2     vertical sync width, lines
//  V_BP     33    vertical back porch, lines
//  H_SYNC_POL 0   hSync asserted level (0 = active-low)
//  V_SYNC_POL 0   vSync asserted level
//  PIX_DIV  4     clk cycles per pixel, >=1 (4 -> 25 MHz pixel from 100 MHz)
//  COORD_W  10    coordinate width; must hold H_TOTAL-1 and V_TOTAL-1
// PORTS
//  clk        in   1        system clock
//  reset      in   1        asynchronous, active-low reset
//  enable     in   1        1 = run; 0 = synchronously hold in restart state
//  hSync      out  1        horizontal sync, polarity H_SYNC_POL
//  vSync      out  1        vertical sync, polarity V_SYNC_POL
//  dataEnable out  1        1 while (xPosition<H_ACTIVE && yPosition<V_ACTIVE)
//  xPosition  out  COORD_W  horizontal counter, 0..H_TOTAL-1
//  yPosition  out  COORD_W  vertical counter, 0..V_TOTAL-1
//  pixelTick  out  1        first clk of each pixel period
//  lineStart  out  1        pixelTick && xPosition==0
//  frameStart out  1        pixelTick && xPosition==0 && yPosition==0
// BEHAVIOUR
//  - H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise (defaults 800, 525).
//  - Restart state (reset low, or enable low at a clk edge): divider=PIX_DIV-1,
//    xPosition=H_TOTAL-1, yPosition=V_TOTAL-1, hSync/vSync deasserted, dataEnable,
//    pixelTick, lineStart, frameStart = 0. Reset is async; enable restart is synchronous.
//  - Divider counts 0..PIX_DIV-1 each clk; a pixel advance occurs on the edge where it wraps to 0.
//  - On advance: x+1; at x==H_TOTAL-1, x->0 and y+1; at y==V_TOTAL-1 also, y->0.
//  - First edge after restart with enable=1 lands on (0,0): frameStart=lineStart=pixelTick=1.
//  - All outputs are registered and updated on the same edge as the counters (zero skew).
//    They are derived from next-state values; no combinational path from inputs to outputs.
//  - hSync asserted iff H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC. vSync uses the same rule with V_* on y.
//  - Strobes are high for exactly one clk. With PIX_DIV=1, pixelTick is constantly 1 while running.
//  - Counters never exceed TOTAL-1; all compares are unsigned, COORD_W bits.
//  - enable dropping mid-line: the next edge loads the restart state; no partial line completes.
// STRUCTURE
//  - Package vga_timing_pkg: mode constants (640x480@60, 800x600@60) as localparam sets, plus the
//    H_TOTAL/V_TOTAL derivation function.
//  - Sub-module vga_pix_div: clock-enable divider (PIX_DIV, restart input, advance output).
//  - Elaboration check: fail if PIX_DIV<1 or 2**COORD_W < max(H_TOTAL,V_TOTAL).
// TESTING
//  1. Reset low 5 clks, release with enable=1 (defaults): outputs (799,524), DE=0, syncs=1;
//     next edge -> (0,0), DE=1, frameStart=1; x advances every 4 clks.
//  2. Line 0: DE high for 2560 clks, falls at x=640; hSync low exactly x=656..751;
//     x 799->0, y 0->1 with lineStart.
//  3. Frame: vSync low exactly y=490..491; consecutive frameStart pulses 1,680,000 clks apart.
//  4. enable=0 at (300,100): next edge gives the restart state; enable=1 -> next edge (0,0), frameStart.
//  5. Reset asserted mid-frame between clk edges: outputs take restart values immediately, no edge needed.
//  6. PIX_DIV=1, H 8/2/2/2, V 4/1/1/1: pixelTick constant 1; hSync low x=10..11;
//     frameStart period 98 clks.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared mode constants and timing helpers for the raster timing generator.
package vga_timing_pkg;

  // 640x480 @ 60 Hz, 25.175 MHz nominal pixel clock, both syncs active-low.
  localparam int unsigned VGA640_H_ACTIVE = 640;
  localparam int unsigned VGA640_H_FP     = 16;
  localparam int unsigned VGA640_H_SYNC   = 96;
  localparam int unsigned VGA640_H_BP     = 48;
  localparam int unsigned VGA640_V_ACTIVE = 480;
  localparam int unsigned VGA640_V_FP     = 10;
  localparam int unsigned VGA640_V_SYNC   = 2;
  localparam int unsigned VGA640_V_BP     = 33;
  localparam bit          VGA640_SYNC_POL = 1'b0;

  // 800x600 @ 60 Hz, 40 MHz nominal pixel clock, both syncs active-high.
  localparam int unsigned SVGA800_H_ACTIVE = 800;
  localparam int unsigned SVGA800_H_FP     = 40;
  localparam int unsigned SVGA800_H_SYNC   = 128;
  localparam int unsigned SVGA800_H_BP     = 88;
  localparam int unsigned SVGA800_V_ACTIVE = 600;
  localparam int unsigned SVGA800_V_FP     = 1;
  localparam int unsigned SVGA800_V_SYNC   = 4;
  localparam int unsigned SVGA800_V_BP     = 23;
  localparam bit          SVGA800_SYNC_POL = 1'b1;

  // Total period of one axis (pixels per line or lines per frame).
  function automatic int unsigned calcTotal(input int unsigned active, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int unsigned maxOf(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: run control in, syncs/coordinates/strobes out.
interface vga_timing_gen_if #(
  parameter int unsigned COORD_W = 10
) ();

  logic               enable;
  logic               hSync;
  logic               vSync;
  logic               dataEnable;
  logic [COORD_W-1:0] xPosition;
  logic [COORD_W-1:0] yPosition;
  logic               pixelTick;
  logic               lineStart;
  logic               frameStart;

  // Timing generator side.
  modport master (
    input  enable,
    output hSync, vSync, dataEnable, xPosition, yPosition, pixelTick, lineStart, frameStart
  );

  // Consumer side (pixel pipeline, pin driver).
  modport slave (
    output enable,
    input  hSync, vSync, dataEnable, xPosition, yPosition, pixelTick, lineStart, frameStart
  );

endinterface

// File: rtl/vga_pix_div.sv
// Clock-enable divider: advance is high on the clk edge where the count wraps to 0.
module vga_pix_div #(
  parameter int unsigned PIX_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic advance
);

  localparam int unsigned DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

  logic [DIV_W-1:0] divQ, divD;

  // Restart parks the count at its last value so the first running edge advances.
  always_comb begin
    divD = divQ;
    if (restart) begin
      divD = DIV_LAST;
    end else if (divQ == DIV_LAST) begin
      divD = '0;
    end else begin
      divD = divQ + 1'b1;
    end
  end

  // Divider state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      divQ <= DIV_LAST;
    end else begin
      divQ <= divD;
    end
  end

  assign advance = !restart && (divQ == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator with pixel-rate clock enable and frame strobes.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = VGA640_H_ACTIVE,
  parameter int unsigned H_FP       = VGA640_H_FP,
  parameter int unsigned H_SYNC     = VGA640_H_SYNC,
  parameter int unsigned H_BP       = VGA640_H_BP,
  parameter int unsigned V_ACTIVE   = VGA640_V_ACTIVE,
  parameter int unsigned V_FP       = VGA640_V_FP,
  parameter int unsigned V_SYNC     = VGA640_V_SYNC,
  parameter int unsigned V_BP       = VGA640_V_BP,
  parameter bit          H_SYNC_POL = VGA640_SYNC_POL,
  parameter bit          V_SYNC_POL = VGA640_SYNC_POL,
  parameter int unsigned PIX_DIV    = 4,
  parameter int unsigned COORD_W    = 10
) (
  input  logic             clk,
  input  logic             reset,
  vga_timing_gen_if.master vga
);

  localparam int unsigned H_TOTAL = calcTotal(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = calcTotal(V_ACTIVE, V_FP, V_SYNC, V_BP);

  // Window bounds are one bit wider so a sync ending exactly at 2**COORD_W still fits.
  localparam int unsigned EXT_W = COORD_W + 1;
  localparam logic [COORD_W-1:0] H_LAST    = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST    = COORD_W'(V_TOTAL - 1);
  localparam logic [EXT_W-1:0]   H_ACT_END = EXT_W'(H_ACTIVE);
  localparam logic [EXT_W-1:0]   V_ACT_END = EXT_W'(V_ACTIVE);
  localparam logic [EXT_W-1:0]   H_SYN_BEG = EXT_W'(H_ACTIVE + H_FP);
  localparam logic [EXT_W-1:0]   H_SYN_END = EXT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [EXT_W-1:0]   V_SYN_BEG = EXT_W'(V_ACTIVE + V_FP);
  localparam logic [EXT_W-1:0]   V_SYN_END = EXT_W'(V_ACTIVE + V_FP + V_SYNC);

  if (PIX_DIV < 1 || (longint'(1) << COORD_W) < longint'(maxOf(H_TOTAL, V_TOTAL)))
  begin : gBadParams
    $error("vga_timing_gen: PIX_DIV must be >= 1 and COORD_W must cover H_TOTAL/V_TOTAL");
  end

  logic               advance;
  logic [COORD_W-1:0] xQ, xD, yQ, yD;
  logic [EXT_W-1:0]   xExt, yExt;
  logic               hSyncQ, vSyncQ, deQ, tickQ, lineQ, frameQ;

  vga_pix_div #(
    .PIX_DIV (PIX_DIV)
  ) uPixDiv (
    .clk     (clk),
    .reset   (reset),
    .restart (!vga.enable),
    .advance (advance)
  );

  // Next raster position; enable low parks both counters at their last value.
  always_comb begin
    xD = xQ;
    yD = yQ;
    if (!vga.enable) begin
      xD = H_LAST;
      yD = V_LAST;
    end else if (advance) begin
      if (xQ == H_LAST) begin
        xD = '0;
        yD = (yQ == V_LAST) ? '0 : yQ + 1'b1;
      end else begin
        xD = xQ + 1'b1;
      end
    end
  end

  assign xExt = {1'b0, xD};
  assign yExt = {1'b0, yD};

  // Counters and outputs share one edge; outputs are decoded from next-state position.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      xQ     <= H_LAST;
      yQ     <= V_LAST;
      hSyncQ <= !H_SYNC_POL;
      vSyncQ <= !V_SYNC_POL;
      deQ    <= 1'b0;
      tickQ  <= 1'b0;
      lineQ  <= 1'b0;
      frameQ <= 1'b0;
    end else if (!vga.enable) begin
      xQ     <= H_LAST;
      yQ     <= V_LAST;
      hSyncQ <= !H_SYNC_POL;
      vSyncQ <= !V_SYNC_POL;
      deQ    <= 1'b0;
      tickQ  <= 1'b0;
      lineQ  <= 1'b0;
      frameQ <= 1'b0;
    end else begin
      xQ     <= xD;
      yQ     <= yD;
      hSyncQ <= ((xExt >= H_SYN_BEG) && (xExt < H_SYN_END)) ? H_SYNC_POL : !H_SYNC_POL;
      vSyncQ <= ((yExt >= V_SYN_BEG) && (yExt < V_SYN_END)) ? V_SYNC_POL : !V_SYNC_POL;
      deQ    <= (xExt < H_ACT_END) && (yExt < V_ACT_END);
      tickQ  <= advance;
      lineQ  <= advance && (xD == '0);
      frameQ <= advance && (xD == '0) && (yD == '0);
    end
  end

  assign vga.xPosition  = xQ;
  assign vga.yPosition  = yQ;
  assign vga.hSync      = hSyncQ;
  assign vga.vSync      = vSyncQ;
  assign vga.dataEnable = deQ;
  assign vga.pixelTick  = tickQ;
  assign vga.lineStart  = lineQ;
  assign vga.frameStart = frameQ;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 timing on dutA, a tiny PIX_DIV=1 mode on dutB.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rstA;
  logic rstB;
  int   nChecks = 0;
  int   nPassed = 0;

  always #5 clk = ~clk;

  vga_timing_gen_if #(.COORD_W(10)) vgaA ();
  vga_timing_gen_if #(.COORD_W(4))  vgaB ();

  vga_timing_gen dutA (
    .clk   (clk),
    .reset (rstA),
    .vga   (vgaA)
  );

  vga_timing_gen #(
    .H_ACTIVE (8),
    .H_FP     (2),
    .H_SYNC   (2),
    .H_BP     (2),
    .V_ACTIVE (4),
    .V_FP     (1),
    .V_SYNC   (1),
    .V_BP     (1),
    .PIX_DIV  (1),
    .COORD_W  (4)
  ) dutB (
    .clk   (clk),
    .reset (rstB),
    .vga   (vgaB)
  );

  task automatic checkEq(input string tag, input int unsigned got, input int unsigned exp);
    nChecks++;
    if (got == exp) nPassed++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int deHigh, deFallX, hMin, hMax, hLow, lsCount, vLow, vMin, vMax;
    int tickCount, fs1, fs2, xMax, yMax;

    rstA = 1'b0;
    rstB = 1'b0;
    vgaA.enable = 1'b1;
    vgaB.enable = 1'b1;

    // Reset state
    tick(5);
    checkEq("rst x", vgaA.xPosition, 799);
    checkEq("rst y", vgaA.yPosition, 524);
    checkEq("rst de", vgaA.dataEnable, 0);
    checkEq("rst hsync", vgaA.hSync, 1);
    checkEq("rst vsync", vgaA.vSync, 1);
    checkEq("rst tick", vgaA.pixelTick, 0);
    checkEq("rst frame", vgaA.frameStart, 0);

    rstA = 1'b1;
    tick(1);
    checkEq("first x", vgaA.xPosition, 0);
    checkEq("first y", vgaA.yPosition, 0);
    checkEq("first de", vgaA.dataEnable, 1);
    checkEq("first frame", vgaA.frameStart, 1);
    checkEq("first line", vgaA.lineStart, 1);
    checkEq("first tick", vgaA.pixelTick, 1);
    tick(1);
    checkEq("tick drop", vgaA.pixelTick, 0);
    checkEq("frame drop", vgaA.frameStart, 0);
    checkEq("x hold", vgaA.xPosition, 0);
    tick(3);
    checkEq("x step", vgaA.xPosition, 1);
    checkEq("x step tick", vgaA.pixelTick, 1);

    // Restart via enable, then sweep line 0 (800 pixels x 4 clks)
    vgaA.enable = 1'b0;
    tick(1);
    vgaA.enable = 1'b1;
    tick(1);
    deHigh = 0; deFallX = -1; hMin = 9999; hMax = -1; hLow = 0; lsCount = 0; vLow = 0;
    for (int k = 0; k < 3200; k++) begin
      if (vgaA.dataEnable) deHigh++;
      else if (deFallX < 0) deFallX = int'(vgaA.xPosition);
      if (!vgaA.hSync) begin
        hLow++;
        if (int'(vgaA.xPosition) < hMin) hMin = int'(vgaA.xPosition);
        if (int'(vgaA.xPosition) > hMax) hMax = int'(vgaA.xPosition);
      end
      if (vgaA.lineStart) lsCount++;
      if (!vgaA.vSync) vLow++;
      tick(1);
    end
    checkEq("line de clks", deHigh, 2560);
    checkEq("line de fall x", deFallX, 640);
    checkEq("hsync first x", hMin, 656);
    checkEq("hsync last x", hMax, 751);
    checkEq("hsync clks", hLow, 384);
    checkEq("line0 linestarts", lsCount, 1);
    checkEq("line0 vsync", vLow, 0);
    checkEq("line1 x", vgaA.xPosition, 0);
    checkEq("line1 y", vgaA.yPosition, 1);
    checkEq("line1 linestart", vgaA.lineStart, 1);
    checkEq("line1 frame", vgaA.frameStart, 0);

    // Enable drop mid-line at (300,1)
    tick(1200);
    checkEq("mid x", vgaA.xPosition, 300);
    checkEq("mid y", vgaA.yPosition, 1);
    vgaA.enable = 1'b0;
    tick(1);
    checkEq("en0 x", vgaA.xPosition, 799);
    checkEq("en0 y", vgaA.yPosition, 524);
    checkEq("en0 de", vgaA.dataEnable, 0);
    checkEq("en0 tick", vgaA.pixelTick, 0);
    tick(3);
    checkEq("en0 hold x", vgaA.xPosition, 799);
    vgaA.enable = 1'b1;
    tick(1);
    checkEq("en1 x", vgaA.xPosition, 0);
    checkEq("en1 y", vgaA.yPosition, 0);
    checkEq("en1 frame", vgaA.frameStart, 1);

    // Async reset between edges
    tick(10);
    #2;
    rstA = 1'b0;
    #1;
    checkEq("async x", vgaA.xPosition, 799);
    checkEq("async y", vgaA.yPosition, 524);
    checkEq("async de", vgaA.dataEnable, 0);
    checkEq("async hsync", vgaA.hSync, 1);

    // Tiny mode, PIX_DIV=1: 14 x 7 = 98 clks per frame
    tick(1);
    rstB = 1'b1;
    tick(1);
    checkEq("b first frame", vgaB.frameStart, 1);
    tickCount = 0; hMin = 99; hMax = -1; hLow = 0; vMin = 99; vMax = -1; vLow = 0;
    deHigh = 0; fs1 = -1; fs2 = -1; xMax = 0; yMax = 0;
    for (int k = 0; k < 196; k++) begin
      if (vgaB.pixelTick) tickCount++;
      if (vgaB.dataEnable) deHigh++;
      if (!vgaB.hSync) begin
        hLow++;
        if (int'(vgaB.xPosition) < hMin) hMin = int'(vgaB.xPosition);
        if (int'(vgaB.xPosition) > hMax) hMax = int'(vgaB.xPosition);
      end
      if (!vgaB.vSync) begin
        vLow++;
        if (int'(vgaB.yPosition) < vMin) vMin = int'(vgaB.yPosition);
        if (int'(vgaB.yPosition) > vMax) vMax = int'(vgaB.yPosition);
      end
      if (vgaB.frameStart) begin
        if (fs1 < 0) fs1 = k;
        else if (fs2 < 0) fs2 = k;
      end
      if (int'(vgaB.xPosition) > xMax) xMax = int'(vgaB.xPosition);
      if (int'(vgaB.yPosition) > yMax) yMax = int'(vgaB.yPosition);
      tick(1);
    end
    checkEq("b tick constant", tickCount, 196);
    checkEq("b de clks", deHigh, 64);
    checkEq("b hsync first x", hMin, 10);
    checkEq("b hsync last x", hMax, 11);
    checkEq("b hsync clks", hLow, 28);
    checkEq("b vsync first y", vMin, 5);
    checkEq("b vsync last y", vMax, 5);
    checkEq("b vsync clks", vLow, 28);
    checkEq("b frame period", fs2 - fs1, 98);
    checkEq("b x max", xMax, 13);
    checkEq("b y max", yMax, 6);

    // Tiny mode enable drop at (5,2)
    tick(33);
    checkEq("b mid x", vgaB.xPosition, 5);
    checkEq("b mid y", vgaB.yPosition, 2);
    vgaB.enable = 1'b0;
    tick(1);
    checkEq("b en0 x", vgaB.xPosition, 13);
    checkEq("b en0 y", vgaB.yPosition, 6);
    checkEq("b en0 tick", vgaB.pixelTick, 0);
    vgaB.enable = 1'b1;
    tick(1);
    checkEq("b en1 x", vgaB.xPosition, 0);
    checkEq("b en1 y", vgaB.yPosition, 0);
    checkEq("b en1 frame", vgaB.frameStart, 1);

    $display("%0d/%0d checks passed", nPassed, nChecks);
    $finish;
  end

endmodule
